// File: rtl/display_mux_driver_pkg.sv
// ---------------------------------------------------------------------------
// display_mux_driver_pkg
// Shared types and constants for the dual seven-segment multiplex driver.
//   mux_state_t : BLANK (both anodes off) / DRIVE (selected digit lit)
//   SEG_OFF     : all segments dark (active-low)
//   ANODE_OFF   : both anodes disabled (active-low)
// ---------------------------------------------------------------------------
package display_mux_driver_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } mux_state_t;

  localparam logic [6:0] SEG_OFF   = 7'h7F;
  localparam logic [1:0] ANODE_OFF = 2'b11;

endpackage

// File: rtl/sevenseg_decoder.sv
// ---------------------------------------------------------------------------
// sevenseg_decoder
// Purely combinational hex to seven-segment decoder, active-low outputs.
// Ports:
//   value_i : 4-bit hex digit
//   seg_o   : segments {g,f,e,d,c,b,a}, 0 = segment lit
// ---------------------------------------------------------------------------
module sevenseg_decoder (
  input  logic [3:0] value_i,
  output logic [6:0] seg_o
);

  // Glyph table; lowercase b and d keep them distinguishable from 8 and 0.
  always_comb begin
    seg_o = 7'h7F;
    case (value_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/display_mux_driver.sv
// ---------------------------------------------------------------------------
// display_mux_driver
// Time-multiplexed driver for a dual seven-segment display. Every toggle of
// io_select starts a blanking gap (both anodes off) before the newly
// selected digit is lit, which suppresses ghosting. Digit values are staged
// on load and only promoted to the display registers on a select toggle.
// Ports:
//   clk       : system clock
//   reset     : asynchronous, active-high reset
//   io_select : digit select from the output-select divider (0/1)
//   load      : strobe capturing digit0/digit1 into staging
//   digit0/1  : hex values for display 0 and display 1
//   seg       : registered active-low segments {g,f,e,d,c,b,a}
//   anode     : registered active-low anodes, anode[i] enables digit i
// ---------------------------------------------------------------------------
module display_mux_driver
  import display_mux_driver_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       io_select,
  input  logic       load,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  output logic [6:0] seg,
  output logic [1:0] anode
);

  // A zero-length gap still needs a one-bit counter to stay well formed.
  localparam int unsigned CW = (BLANK_CYCLES == 0) ? 1 : $clog2(BLANK_CYCLES + 1);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(BLANK_CYCLES);

  mux_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_q;
  logic          active_sel_q, active_sel_d;
  logic [3:0]    stage0_q, stage0_d, stage1_q, stage1_d;
  logic [3:0]    disp0_q, disp0_d, disp1_q, disp1_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    anode_q, anode_d;

  logic          selEdge;
  logic [3:0]    shownDigit;
  logic [6:0]    decodedSeg;

  assign selEdge    = io_select ^ sel_q;
  assign shownDigit = active_sel_q ? disp1_q : disp0_q;

  sevenseg_decoder u_decoder (
    .value_i (shownDigit),
    .seg_o   (decodedSeg)
  );

  // Staging registers: the most recent load before a select toggle wins.
  always_comb begin
    stage0_d = stage0_q;
    stage1_d = stage1_q;
    if (load) begin
      stage0_d = digit0;
      stage1_d = digit1;
    end
  end

  // Next-state logic. A toggle always restarts blanking, even from BLANK,
  // and latches the digits; a same-cycle load bypasses staging so the value
  // shown after the gap is never stale.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    active_sel_d = active_sel_q;
    disp0_d      = disp0_q;
    disp1_d      = disp1_q;
    if (selEdge) begin
      state_d      = BLANK;
      cnt_d        = CNT_RELOAD;
      active_sel_d = io_select;
      disp0_d      = load ? digit0 : stage0_q;
      disp1_d      = load ? digit1 : stage1_q;
    end else if (state_q == BLANK) begin
      if (cnt_q == '0) begin
        state_d = DRIVE;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // Output decode from the current state; registering it means the anodes
  // only ever show one lit digit, and never any during BLANK.
  always_comb begin
    seg_d   = SEG_OFF;
    anode_d = ANODE_OFF;
    if (state_q == DRIVE) begin
      seg_d   = decodedSeg;
      anode_d = active_sel_q ? 2'b01 : 2'b10;
    end
  end

  // State, counter and select tracking. Reset behaves like a fresh toggle
  // to digit 0, so an idle divider still ends up showing digit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BLANK;
      cnt_q        <= CNT_RELOAD;
      sel_q        <= 1'b0;
      active_sel_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= io_select;
      active_sel_q <= active_sel_d;
    end
  end

  // Digit storage: staged values and the values currently on display.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage0_q <= '0;
      stage1_q <= '0;
      disp0_q  <= '0;
      disp1_q  <= '0;
    end else begin
      stage0_q <= stage0_d;
      stage1_q <= stage1_d;
      disp0_q  <= disp0_d;
      disp1_q  <= disp1_d;
    end
  end

  // Output registers, forced dark immediately on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q   <= SEG_OFF;
      anode_q <= ANODE_OFF;
    end else begin
      seg_q   <= seg_d;
      anode_q <= anode_d;
    end
  end

  assign seg   = seg_q;
  assign anode = anode_q;

endmodule

// File: doc/display_mux_driver.md
Name: display_mux_driver

Overview:
- Time-multiplexed driver for a dual seven-segment display, downstream of the 240 Hz output-select divider.
- Consumes the divider's io_select toggle, inserts a blanking gap on every digit switch to suppress ghosting, decodes the selected 4-bit digit and drives active-low segments and anodes.
- New digit values are staged and applied only at switch boundaries, so a digit never changes mid-display.

Parameters:
- BLANK_CYCLES, 1024, clk cycles both anodes are held off after each io_select edge; 0 means no blanking gap.
- CW, $clog2(BLANK_CYCLES+1), blank counter width; derived, not overridden.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- io_select  input  1  digit select from the divider, same clock domain; 0 = digit 0, 1 = digit 1
- load  input  1  single-cycle strobe that captures digit0/digit1 into staging registers
- digit0  input  4  hex value for display 0
- digit1  input  4  hex value for display 1
- seg  output  7  active-low segments {g,f,e,d,c,b,a}, registered
- anode  output  2  active-low anode enables, anode[i] enables digit i, registered

Behaviour:
- Reset values:
  - seg = 7'h7F, anode = 2'b11.
  - State = BLANK, blank counter = BLANK_CYCLES, active_sel = 0, sel_q = 0.
  - Staging and display registers = 0.
- Edge detect: edge = io_select ^ sel_q. sel_q <= io_select every cycle.
- Staging: when load = 1, stage0/stage1 <= digit0/digit1. The last load before an edge wins.
- State BLANK:
  - Registered outputs go to anode = 11 and seg = 7F.
  - Counter decrements once per cycle.
  - When the counter is 0 and there is no edge, go to DRIVE on the next cycle.
- State DRIVE:
  - anode[active_sel] = 0 and the other anode = 1.
  - seg = decode(active_sel ? disp1 : disp0).
- Edge in any state:
  - Next state = BLANK, counter <= BLANK_CYCLES, active_sel <= io_select.
  - disp0/disp1 <= (load ? digit0/digit1 : stage0/stage1). A simultaneous load bypasses staging.
- Edge while already in BLANK: the counter restarts; no glitch reaches the anodes.
- Latency:
  - Edge at cycle N (io_select changes before edge N): anodes read 11 from cycle N+1.
  - Selected anode goes low at cycle N+BLANK_CYCLES+2.
  - With BLANK_CYCLES = 0, that is cycle N+2, with one blank cycle.
- Both anodes are never low in the same cycle. Neither anode is ever low in BLANK.
- If no edge ever arrives after reset: BLANK expires and digit 0 is displayed with value 0.
- Reset asserted mid-operation: all outputs are forced to reset values immediately (asynchronous), and staged values are lost.
- Decode, active-low:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110

Decomposition:
- Shared package: typedef enum logic {BLANK, DRIVE} mux_state_t; constant SEG_OFF = 7'h7F; constant ANODE_OFF = 2'b11.
- Sub-module sevenseg_decoder: purely combinational, 4-bit input to 7-bit active-low output.
- Reuse the existing flop/flopenr library cells for sel_q, staging and display registers. The FSM and counter are local.

Test Plan:
1. Reset with BLANK_CYCLES = 4 and io_select held at 0 -> anode = 11 and seg = 7F through cycle 5; anode = 10 and seg = 1000000 from cycle 6.
2. load with digit0 = 3 and digit1 = A, then toggle io_select 0->1 -> anode = 11 for 5 cycles, then anode = 01 and seg = 0001000. Toggle back -> anode = 10 and seg = 0110000.
3. load with digit1 = 8 while in DRIVE on digit 1 -> seg stays 0001000 until the next edge. After the edges 1->0->1, digit 1 shows 0000000.
4. load in the same cycle as an edge with digit0 = 5 -> after blanking, digit 0 shows 0010010, with no stale value.
5. Toggle io_select twice, 2 cycles apart, during BLANK -> the blank counter restarts and anodes stay 11 for 5 cycles after the second edge. A checker confirms anode never equals 00 in any cycle.
6. Assert reset mid-DRIVE -> seg = 7F and anode = 11 in the same cycle. With BLANK_CYCLES = 0, an edge gives exactly 1 blank cycle.
